// File: rtl/pipe_stage_reg_pkg.sv
// Shared core defines: hart id width, NOP/bubble payload encodings and the
// per-stage payload pack/unpack helpers used at each pipe_stage_reg boundary.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package pipe_stage_reg_pkg;

  // Hart configuration shared by every stage boundary.
  localparam int unsigned CORE_HART_ID_W = 2;
  localparam int unsigned CORE_NUM_HARTS = 1 << CORE_HART_ID_W;

  // Default stage payload width and drop counter width.
  localparam int unsigned PSR_DATA_W_DEF = 128;
  localparam int unsigned PSR_CNT_W_DEF  = 8;

  // Canonical NOP instruction (addi x0, x0, 0).
  localparam logic [31:0] CORE_NOP_INSN = 32'h0000_0013;

  // Source selector for loading a slot of the stage register.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,  // slot becomes empty (bubble)
    SRC_MAIN = 2'd1,  // take the current main slot
    SRC_SKID = 2'd2,  // take the current skid slot
    SRC_IN   = 2'd3   // take the incoming entry
  } slot_src_e;

  // IF->ID stage bundle (128 bits).
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
    logic [31:0] pred_target;
    logic [30:0] rsvd;
    logic        pred_taken;
  } if_id_pld_t;

  // ID->EX stage bundle (128 bits).
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
  } id_ex_pld_t;

  // NOP encodings used as BUBBLE at each boundary: the payload carries a
  // real NOP so a bubble that leaks downstream is architecturally harmless.
  localparam if_id_pld_t IF_ID_NOP = '{pc: '0, insn: CORE_NOP_INSN,
                                       pred_target: '0, rsvd: '0,
                                       pred_taken: 1'b0};
  localparam id_ex_pld_t ID_EX_NOP = '{pc: '0, insn: CORE_NOP_INSN,
                                       rs1_val: '0, rs2_val: '0};

  function automatic logic [PSR_DATA_W_DEF-1:0] if_id_pack(input if_id_pld_t p);
    return p;
  endfunction

  function automatic if_id_pld_t if_id_unpack(input logic [PSR_DATA_W_DEF-1:0] d);
    return if_id_pld_t'(d);
  endfunction

  function automatic logic [PSR_DATA_W_DEF-1:0] id_ex_pack(input id_ex_pld_t p);
    return p;
  endfunction

  function automatic id_ex_pld_t id_ex_unpack(input logic [PSR_DATA_W_DEF-1:0] d);
    return id_ex_pld_t'(d);
  endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// Hart-aware pipeline stage register: main slot + skid slot, per-hart kill,
// global flush and a saturating kill/drop counter.
// Latency: 1 cycle push->out_valid; 1 entry/cycle throughput while out_ready.
// Backpressure: in_ready = ~skid_valid & ~reset, registered-only (no
// out_ready->in_ready path); the skid slot absorbs the one in-flight entry.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   in_valid/in_ready     upstream handshake; in_hart_id, in_data payload
//   out_valid/out_ready   downstream handshake; out_hart_id, out_data payload
//   flush                 drop every entry (slots and incoming), not counted
//   kill_mask             per-hart invalidate of slots and incoming entry
//   hart_pending          per-hart "has a valid slot" decode
//   drop_cnt, drop_clr    saturating count of killed entries, sync clear
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int unsigned         DATA_W    = PSR_DATA_W_DEF,
  parameter int unsigned         HART_ID_W = CORE_HART_ID_W,
  parameter logic [DATA_W-1:0]   BUBBLE    = {DATA_W{1'b0}},
  parameter int unsigned         CNT_W     = PSR_CNT_W_DEF,
  localparam int unsigned        NUM_HARTS = 1 << HART_ID_W
) (
  input  logic                 clk,
  input  logic                 reset,

  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [HART_ID_W-1:0] in_hart_id,
  input  logic [DATA_W-1:0]    in_data,

  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [HART_ID_W-1:0] out_hart_id,
  output logic [DATA_W-1:0]    out_data,

  input  logic                 flush,
  input  logic [NUM_HARTS-1:0] kill_mask,
  output logic [NUM_HARTS-1:0] hart_pending,

  output logic [CNT_W-1:0]     drop_cnt,
  input  logic                 drop_clr
);

  // ---------------------------------------------------------------------
  // Slot state
  // ---------------------------------------------------------------------
  logic                 main_vld_q,  main_vld_d;
  logic [HART_ID_W-1:0] main_hart_q, main_hart_d;
  logic [DATA_W-1:0]    main_dat_q,  main_dat_d;

  logic                 skid_vld_q,  skid_vld_d;
  logic [HART_ID_W-1:0] skid_hart_q, skid_hart_d;
  logic [DATA_W-1:0]    skid_dat_q,  skid_dat_d;

  logic [CNT_W-1:0]     drop_cnt_q,  drop_cnt_d;

  // ---------------------------------------------------------------------
  // Kill counter: add 0..3 killed entries, saturating at all-ones.
  // Two guard bits so even CNT_W=1 cannot wrap before the compare.
  // ---------------------------------------------------------------------
  function automatic logic [CNT_W-1:0] add_kills_sat(
    input logic [CNT_W-1:0] cnt,
    input logic [2:0]       kills
  );
    logic [CNT_W+1:0] sum;
    sum = {2'b00, cnt}
        + (CNT_W+2)'(kills[0])
        + (CNT_W+2)'(kills[1])
        + (CNT_W+2)'(kills[2]);
    if (sum > {2'b00, {CNT_W{1'b1}}}) begin
      add_kills_sat = {CNT_W{1'b1}};
    end else begin
      add_kills_sat = sum[CNT_W-1:0];
    end
  endfunction

  // ---------------------------------------------------------------------
  // Handshake and kill qualification
  // ---------------------------------------------------------------------
  logic push, pop;
  logic main_kill, skid_kill, in_kill;
  logic main_keep, skid_keep, in_keep;

  // Only registered state (plus reset) feeds in_ready.
  assign in_ready = ~skid_vld_q & ~reset;

  assign push = in_valid & in_ready;
  assign pop  = main_vld_q & out_ready;

  assign main_kill = main_vld_q & kill_mask[main_hart_q];
  assign skid_kill = skid_vld_q & kill_mask[skid_hart_q];
  assign in_kill   = push & kill_mask[in_hart_id];

  // A killed main entry leaves regardless of pop, so a pop that coincides
  // with the kill is effectively ignored (nothing delivered).
  assign main_keep = main_vld_q & ~main_kill & ~pop;
  assign skid_keep = skid_vld_q & ~skid_kill;
  assign in_keep   = push & ~in_kill;

  // ---------------------------------------------------------------------
  // Slot source selection. Survivors are compacted in program order
  // (main, skid, incoming) into main then skid. At most two survive,
  // because a push is only possible while skid is empty.
  // ---------------------------------------------------------------------
  slot_src_e main_src, skid_src;

  always_comb begin
    main_src = SRC_NONE;
    skid_src = SRC_NONE;
    if (!flush) begin
      if (main_keep) begin
        main_src = SRC_MAIN;
      end else if (skid_keep) begin
        main_src = SRC_SKID;
      end else if (in_keep) begin
        main_src = SRC_IN;
      end

      if (main_keep && skid_keep) begin
        skid_src = SRC_SKID;
      end else if ((main_keep || skid_keep) && in_keep) begin
        skid_src = SRC_IN;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Slot next-state muxes. An empty slot is always loaded with BUBBLE and
  // hart 0 so a flushed/killed slot never exposes stale payload.
  // ---------------------------------------------------------------------
  always_comb begin
    main_vld_d  = 1'b0;
    main_hart_d = '0;
    main_dat_d  = BUBBLE;
    case (main_src)
      SRC_MAIN: begin
        main_vld_d  = 1'b1;
        main_hart_d = main_hart_q;
        main_dat_d  = main_dat_q;
      end
      SRC_SKID: begin
        main_vld_d  = 1'b1;
        main_hart_d = skid_hart_q;
        main_dat_d  = skid_dat_q;
      end
      SRC_IN: begin
        main_vld_d  = 1'b1;
        main_hart_d = in_hart_id;
        main_dat_d  = in_data;
      end
      default: begin
        main_vld_d  = 1'b0;
        main_hart_d = '0;
        main_dat_d  = BUBBLE;
      end
    endcase
  end

  always_comb begin
    skid_vld_d  = 1'b0;
    skid_hart_d = '0;
    skid_dat_d  = BUBBLE;
    case (skid_src)
      SRC_SKID: begin
        skid_vld_d  = 1'b1;
        skid_hart_d = skid_hart_q;
        skid_dat_d  = skid_dat_q;
      end
      SRC_IN: begin
        skid_vld_d  = 1'b1;
        skid_hart_d = in_hart_id;
        skid_dat_d  = in_data;
      end
      default: begin
        skid_vld_d  = 1'b0;
        skid_hart_d = '0;
        skid_dat_d  = BUBBLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Drop counter. Flushed entries are not counted; clear beats increment.
  // ---------------------------------------------------------------------
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop_clr) begin
      drop_cnt_d = '0;
    end else if (!flush) begin
      drop_cnt_d = add_kills_sat(drop_cnt_q, {in_kill, skid_kill, main_kill});
    end
  end

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      main_vld_q  <= 1'b0;
      main_hart_q <= '0;
      main_dat_q  <= BUBBLE;
      skid_vld_q  <= 1'b0;
      skid_hart_q <= '0;
      skid_dat_q  <= BUBBLE;
      drop_cnt_q  <= '0;
    end else begin
      main_vld_q  <= main_vld_d;
      main_hart_q <= main_hart_d;
      main_dat_q  <= main_dat_d;
      skid_vld_q  <= skid_vld_d;
      skid_hart_q <= skid_hart_d;
      skid_dat_q  <= skid_dat_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign out_valid   = main_vld_q;
  assign out_hart_id = main_hart_q;
  assign out_data    = main_dat_q;
  assign drop_cnt    = drop_cnt_q;

  always_comb begin
    hart_pending = '0;
    if (main_vld_q) hart_pending[main_hart_q] = 1'b1;
    if (skid_vld_q) hart_pending[skid_hart_q] = 1'b1;
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a queue model.
// Latency/backpressure: n/a.
module tb_pipe_stage_reg;

  localparam int DW = 128;
  localparam logic [DW-1:0] TB_BUBBLE = 128'h00000000_00000013_00000000_00000000;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_hart_id;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [1:0]    out_hart_id;
  logic [DW-1:0] out_data;
  logic          flush;
  logic [3:0]    kill_mask;
  logic [3:0]    hart_pending;
  logic [7:0]    drop_cnt;
  logic          drop_clr;

  pipe_stage_reg #(
    .DATA_W(DW), .HART_ID_W(2), .BUBBLE(TB_BUBBLE), .CNT_W(8)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_hart_id(in_hart_id), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_hart_id(out_hart_id), .out_data(out_data),
    .flush(flush), .kill_mask(kill_mask), .hart_pending(hart_pending),
    .drop_cnt(drop_cnt), .drop_clr(drop_clr)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: ordered list of live entries (front = main slot).
  typedef struct {
    logic [1:0]    hart;
    logic [DW-1:0] data;
  } ent_t;

  ent_t m_q[$];
  int   m_cnt = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Compare every DUT output against the model.
  task automatic compare();
    logic [3:0] hp;
    hp = '0;
    foreach (m_q[i]) hp[m_q[i].hart] = 1'b1;
    chk("in_ready", DW'(in_ready), DW'((m_q.size() < 2) && !reset));
    chk("out_valid", DW'(out_valid), DW'(m_q.size() > 0));
    if (m_q.size() > 0) begin
      chk("out_hart_id", DW'(out_hart_id), DW'(m_q[0].hart));
      chk("out_data", out_data, m_q[0].data);
    end
    chk("hart_pending", DW'(hart_pending), DW'(hp));
    chk("drop_cnt", DW'(drop_cnt), DW'(m_cnt));
  endtask

  // One clock: advance model with the inputs held across the edge, then check.
  task automatic cycle();
    ent_t nq[$];
    int   killed;
    bit   m_push;
    m_push = in_valid && (m_q.size() < 2) && !reset;
    @(posedge clk);
    if (reset) begin
      m_q.delete();
      m_cnt = 0;
    end else begin
      if (flush) begin
        m_q.delete();
      end else begin
        killed = 0;
        nq = {};
        foreach (m_q[i]) begin
          if (kill_mask[m_q[i].hart]) killed++;
          else if (i == 0 && out_ready) begin
            // delivered downstream
          end else nq.push_back(m_q[i]);
        end
        if (m_push) begin
          if (kill_mask[in_hart_id]) killed++;
          else nq.push_back('{hart: in_hart_id, data: in_data});
        end
        m_q = nq;
        m_cnt = (m_cnt + killed > 255) ? 255 : m_cnt + killed;
      end
      if (drop_clr) m_cnt = 0;
    end
    #1;
    compare();
  endtask

  task automatic drive(input bit v, input logic [1:0] h, input logic [DW-1:0] d);
    in_valid   = v;
    in_hart_id = h;
    in_data    = d;
  endtask

  initial begin
    reset = 1'b1; drive(0, 2'd0, '0);
    out_ready = 1'b0; flush = 1'b0; kill_mask = 4'h0; drop_clr = 1'b0;

    // Reset state
    cycle(); cycle();
    chk("rst_in_ready", DW'(in_ready), DW'(0));
    chk("rst_out_valid", DW'(out_valid), DW'(0));
    chk("rst_out_data", out_data, TB_BUBBLE);
    chk("rst_drop_cnt", DW'(drop_cnt), DW'(0));
    chk("rst_hart_pending", DW'(hart_pending), DW'(0));
    reset = 1'b0;
    #1;
    chk("in_ready_after_rst", DW'(in_ready), DW'(1));

    // Stream: four back-to-back entries at full throughput
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      drive(1, 2'd0, DW'(k));
      cycle();
      chk("stream_data", out_data, DW'(k));
      chk("stream_in_ready", DW'(in_ready), DW'(1));
    end
    drive(0, 2'd0, '0);
    cycle();
    chk("stream_drained", DW'(out_valid), DW'(0));

    // Back-pressure: A to main, B to skid, C held upstream
    out_ready = 1'b0;
    drive(1, 2'd0, 128'hA); cycle();
    drive(1, 2'd0, 128'hB); cycle();
    chk("bp_in_ready_low", DW'(in_ready), DW'(0));
    chk("bp_hold_A", out_data, 128'hA);
    drive(1, 2'd0, 128'hC); cycle();
    chk("bp_still_A", out_data, 128'hA);
    out_ready = 1'b1;
    cycle();
    chk("bp_out_B", out_data, 128'hB);
    chk("bp_in_ready_back", DW'(in_ready), DW'(1));
    cycle();
    chk("bp_out_C", out_data, 128'hC);
    drive(0, 2'd0, '0); cycle();
    chk("bp_empty", DW'(out_valid), DW'(0));

    // Selective kill: main=hart1, skid=hart2, kill hart1
    out_ready = 1'b0;
    drive(1, 2'd1, 128'h11); cycle();
    drive(1, 2'd2, 128'h22); cycle();
    drive(0, 2'd0, '0);
    kill_mask = 4'b0010; cycle();
    chk("sk_out_hart", DW'(out_hart_id), DW'(2));
    chk("sk_out_data", out_data, 128'h22);
    chk("sk_pending", DW'(hart_pending), DW'(4'b0100));
    chk("sk_drop_cnt", DW'(drop_cnt), DW'(1));
    // Kill main during a pop: nothing delivered, slot becomes bubble
    kill_mask = 4'b0100; out_ready = 1'b1; cycle();
    chk("kpop_valid", DW'(out_valid), DW'(0));
    chk("kpop_bubble", out_data, TB_BUBBLE);
    chk("kpop_drop_cnt", DW'(drop_cnt), DW'(2));

    // Kill on push
    kill_mask = 4'b1000; drive(1, 2'd3, 128'h44);
    #1;
    chk("kp_in_ready", DW'(in_ready), DW'(1));
    cycle();
    chk("kp_valid", DW'(out_valid), DW'(0));
    chk("kp_drop_cnt", DW'(drop_cnt), DW'(3));

    // Flush + kill + push with both slots full
    kill_mask = 4'h0; out_ready = 1'b0;
    drive(1, 2'd0, 128'h31); cycle();
    drive(1, 2'd1, 128'h32); cycle();
    drive(1, 2'd2, 128'h33);
    flush = 1'b1; kill_mask = 4'hF; cycle();
    chk("fl_valid", DW'(out_valid), DW'(0));
    chk("fl_bubble", out_data, TB_BUBBLE);
    chk("fl_drop_cnt", DW'(drop_cnt), DW'(3));
    chk("fl_pending", DW'(hart_pending), DW'(0));
    kill_mask = 4'h0; cycle();  // flush with push into empty stage
    chk("fl_push_dropped", DW'(out_valid), DW'(0));
    flush = 1'b0;

    // Saturation and clear priority
    out_ready = 1'b1; kill_mask = 4'b1000; drive(1, 2'd3, 128'h55);
    for (int k = 0; k < 260; k++) cycle();
    chk("sat_255", DW'(drop_cnt), DW'(255));
    cycle();
    chk("sat_hold", DW'(drop_cnt), DW'(255));
    drop_clr = 1'b1; cycle();
    chk("clr_wins", DW'(drop_cnt), DW'(0));
    drop_clr = 1'b0;

    // Reset mid-stall with both slots full and a nonzero counter
    cycle();  // one more killed push
    kill_mask = 4'h0; out_ready = 1'b0;
    drive(1, 2'd1, 128'h61); cycle();
    drive(1, 2'd2, 128'h62); cycle();
    drive(0, 2'd0, '0);
    reset = 1'b1;
    #1;
    chk("mrst_in_ready_low", DW'(in_ready), DW'(0));
    cycle();
    chk("mrst_valid", DW'(out_valid), DW'(0));
    chk("mrst_drop_cnt", DW'(drop_cnt), DW'(0));
    reset = 1'b0;
    #1;
    chk("mrst_in_ready_high", DW'(in_ready), DW'(1));

    // Randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      reset     = ($urandom_range(0, 199) == 0);
      flush     = ($urandom_range(0, 24) == 0);
      kill_mask = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      drop_clr  = ($urandom_range(0, 59) == 0);
      out_ready = ($urandom_range(0, 9) < 6);
      drive($urandom_range(0, 9) < 7, 2'($urandom_range(0, 3)),
            {$urandom(), $urandom(), $urandom(), $urandom()});
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised, hart-aware pipeline stage register with valid/ready handshake and a two-slot skid buffer. It is the successor to the fixed-width stall/flush stage registers between IF/ID/EX/MEM. It adds per-hart selective kill, back-pressure without combinational ready paths, and a drop counter for the hart control unit. It is instantiated once per stage boundary. The stage's decoded bundle is packed into `in_data`.

## Interface

Parameters:
- `DATA_W`, default 128: width of the packed stage payload.
- `HART_ID_W`, default 2: hart id width; `NUM_HARTS = 1 << HART_ID_W`.
- `BUBBLE`, default `{DATA_W{1'b0}}`: payload value loaded into any invalidated slot (NOP encoding).
- `CNT_W`, default 8: width of `drop_cnt`.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  upstream entry valid.
- `in_ready`  out  1  stage can accept; equals `~skid_valid & ~reset`.
- `in_hart_id`  in  HART_ID_W  hart owning the incoming entry.
- `in_data`  in  DATA_W  incoming payload.
- `out_valid`  out  1  main slot valid.
- `out_ready`  in  1  downstream accepts (deasserted = stall).
- `out_hart_id`  out  HART_ID_W  hart of the main slot.
- `out_data`  out  DATA_W  payload of the main slot.
- `flush`  in  1  global flush of all entries.
- `kill_mask`  in  NUM_HARTS  bit h set invalidates every entry of hart h.
- `hart_pending`  out  NUM_HARTS  bit h set if any valid slot holds hart h.
- `drop_cnt`  out  CNT_W  saturating count of entries discarded by `kill_mask`.
- `drop_clr`  in  1  synchronous clear of `drop_cnt`.

## Operation

- Storage: main slot (`out_*`) and skid slot. Each slot holds valid, hart id and data.
- `push = in_valid & in_ready`; `pop = out_valid & out_ready`.
- Normal behaviour (no flush, no kill hit):
  - push with main empty, or with pop: the entry goes to main. If skid is valid it goes to main first; push cannot occur when skid is valid because `in_ready` is 0.
  - push with main valid and no pop: the entry goes to skid.
  - pop with skid valid: skid moves to main, skid is emptied.
  - pop with no push and no skid: main is emptied.
- Per-hart kill:
  - Any slot whose hart bit is set in `kill_mask` is invalidated and its data set to `BUBBLE`.
  - A pushed entry whose hart is in `kill_mask` completes its handshake and is discarded.
  - Survivors keep program order. If main is killed and skid survives, skid moves to main in the same cycle.
  - A pop in the same cycle as a kill of main is ignored; the killed entry is not counted as delivered.
- Flush: both slots are invalidated with data set to `BUBBLE`, hart id set to 0, and any push that cycle is discarded. Precedence is `flush` > `kill_mask` > normal. Flushed entries do not count toward `drop_cnt`.
- `drop_cnt`: adds the number of entries killed this cycle (0..3: main, skid, incoming). It saturates at `2^CNT_W - 1`.
- `drop_clr` wins over an increment in the same cycle.
- `hart_pending` is a combinational decode of registered slot state only.

## Timing

- Reset values: `out_valid` 0, `out_data` `BUBBLE`, `out_hart_id` 0, skid invalid, `drop_cnt` 0, `hart_pending` 0, `in_ready` 0 while `reset` is high and 1 in the first cycle after.
- Latency: 1 cycle from push to `out_valid` when empty. Throughput is 1 entry/cycle while `out_ready` stays high.
- `in_ready` depends only on registered state, so there is no `out_ready`→`in_ready` combinational path.
- `out_valid`, `out_data` and `out_hart_id` are registered. Once valid and not popped, they hold stable unless flushed or killed.
- After one stall cycle with a push, `in_ready` drops the next cycle. It returns one cycle after the first pop.
- Reset mid-operation discards all entries in the same edge with no drain. `drop_cnt` is cleared.

## Structure

- `HART_ID_W` and the `BUBBLE`/NOP payload encodings belong in the shared core defines package. Payload pack/unpack functions per stage also go there.
- No sub-module. The two-slot skid logic stays inline (about 200 lines).
- The kill-count adder (popcount of 3 bits plus saturation) is a local function.

## Test plan

- Stream: `out_ready`=1, push 4 entries (hart 0, data 1..4) back-to-back → `out_valid` from cycle 1, data 1,2,3,4 on consecutive cycles, `in_ready` stays 1.
- Back-pressure: hold `out_ready`=0, push A, B, C → A in main, B in skid, `in_ready`=0, C held upstream. Raise `out_ready` → outputs A, B, C in order with no loss or duplication.
- Selective kill: main = hart 1, skid = hart 2, assert `kill_mask`=4'b0010 → next cycle main holds the hart 2 entry, `hart_pending`=4'b0100, `drop_cnt`=1.
- Kill on push: push hart 3 with `kill_mask`=4'b1000 → `in_ready`=1, entry discarded, `out_valid` stays 0, `drop_cnt` +1.
- Flush + kill + push together: both slots full, `flush`=1 and `kill_mask`=4'hF → both slots empty, `out_data`=`BUBBLE`, `drop_cnt` unchanged. With `drop_cnt` at 255, a kill → stays at 255; `drop_clr` with a kill → 0.
- Reset mid-stall: both slots full, assert `reset` for 1 cycle → `out_valid` 0, `in_ready` 0 during reset and 1 after, `drop_cnt` 0.
